// File: rtl/free_list_if.sv
// Pop/push/status bundle between the free list and rename/commit logic.
// The free list itself connects through the slave modport.
interface free_list_if #(
  parameter int unsigned SS         = 2,
  parameter int unsigned PR_ENTRIES = 64,
  parameter int unsigned ARCH_REGS  = 32
);
  localparam int unsigned TW = $clog2(PR_ENTRIES);
  localparam int unsigned CW = $clog2(PR_ENTRIES - ARCH_REGS) + 1;

  logic                   pop_free_list;
  logic [SS-1:0][TW-1:0]  free_list_regs;
  logic                   free_list_avail;
  logic [SS-1:0]          push_valid;
  logic [SS-1:0][TW-1:0]  push_reg;
  logic [CW-1:0]          count;
  logic                   overflow_err;

  modport master (
    output pop_free_list, push_valid, push_reg,
    input  free_list_regs, free_list_avail, count, overflow_err
  );

  modport slave (
    input  pop_free_list, push_valid, push_reg,
    output free_list_regs, free_list_avail, count, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: SS tags popped per accepted pop,
// up to SS freed tags pushed per cycle (compacted, p0 dropped).
module free_list #(
  parameter int unsigned SS         = 2,
  parameter int unsigned PR_ENTRIES = 64,
  parameter int unsigned ARCH_REGS  = 32
) (
  input  logic         clk,
  input  logic         rst,
  free_list_if.slave   fl
);
  localparam int unsigned DEPTH = PR_ENTRIES - ARCH_REGS;
  localparam int unsigned TW    = $clog2(PR_ENTRIES);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < SS)) begin : g_bad_depth
    $error("free_list: DEPTH must be a power of two and at least SS");
  end

  logic [TW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic                  pop_acc;
  logic                  ovf;
  logic [SS-1:0]         lane_v;
  logic [SS-1:0][PW-1:0] waddr;
  logic [CW-1:0]         npush;
  logic [CW:0]           cnt_pop, cnt_sum;

  always_comb begin
    pop_acc = fl.pop_free_list && (count_q >= CW'(SS));
    npush   = '0;
    lane_v  = '0;
    waddr   = '0;
    // Valid lanes are packed: each lane writes at tail plus the number of valid lanes before it.
    for (int unsigned i = 0; i < SS; i++) begin
      lane_v[i] = fl.push_valid[i] && (fl.push_reg[i] != '0);
      waddr[i]  = tail_q + PW'(npush);
      if (lane_v[i]) npush = npush + CW'(1);
    end
    cnt_pop = {1'b0, count_q} - (pop_acc ? (CW+1)'(SS) : '0);
    cnt_sum = cnt_pop + {1'b0, npush};
    ovf     = cnt_sum > (CW+1)'(DEPTH);
    head_d  = pop_acc ? head_q + PW'(SS) : head_q;
    tail_d  = ovf ? tail_q : tail_q + PW'(npush);
    count_d = ovf ? cnt_pop[CW-1:0] : cnt_sum[CW-1:0];
    ovf_d   = ovf_q | ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= TW'(ARCH_REGS + k);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(DEPTH);
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (!ovf) begin
        for (int unsigned i = 0; i < SS; i++) begin
          if (lane_v[i]) mem_q[waddr[i]] <= fl.push_reg[i];
        end
      end
    end
  end

  always_comb begin
    fl.free_list_regs = '0;
    for (int unsigned i = 0; i < SS; i++) begin
      fl.free_list_regs[i] = mem_q[head_q + PW'(i)];
    end
  end

  assign fl.free_list_avail = count_q >= CW'(SS);
  assign fl.count           = count_q;
  assign fl.overflow_err    = ovf_q;

  ovf_chk: assert property (@(posedge clk) disable iff (rst) !ovf)
    else $warning("free_list: push overflow, pushes discarded");
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_free_list;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  free_list_if #(.SS(2), .PR_ENTRIES(64), .ARCH_REGS(32)) fl ();

  free_list #(.SS(2), .PR_ENTRIES(64), .ARCH_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list of free tags in FIFO order
  int  q[$];
  bit  m_ovf   = 1'b0;
  bit  started = 1'b0;

  always @(posedge clk) begin : model
    int adds[$];
    bit pa;
    if (rst) begin
      q.delete();
      for (int k = 0; k < 32; k++) q.push_back(32 + k);
      m_ovf   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      adds.delete();
      pa = fl.pop_free_list && (q.size() >= 2);
      for (int i = 0; i < 2; i++)
        if (fl.push_valid[i] && fl.push_reg[i] != 6'd0) adds.push_back(int'(fl.push_reg[i]));
      if (q.size() - (pa ? 2 : 0) + adds.size() > 32) m_ovf = 1'b1;
      else foreach (adds[j]) q.push_back(adds[j]);
      if (pa) begin
        void'(q.pop_front());
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      chk("model_count", int'(fl.count), q.size());
      chk("model_avail", int'(fl.free_list_avail), (q.size() >= 2) ? 1 : 0);
      chk("model_ovf", int'(fl.overflow_err), int'(m_ovf));
      if (q.size() >= 2) begin
        chk("model_lane0", int'(fl.free_list_regs[0]), q[0]);
        chk("model_lane1", int'(fl.free_list_regs[1]), q[1]);
      end
    end
  end

  task automatic cyc(input bit pop, input bit [1:0] pv, input int r0, input int r1);
    fl.pop_free_list = pop;
    fl.push_valid    = pv;
    fl.push_reg[0]   = 6'(r0);
    fl.push_reg[1]   = 6'(r1);
    @(negedge clk);
  endtask

  task automatic chk_state(input string name, input int cnt, input int av, input int ov);
    chk({name, "_count"}, int'(fl.count), cnt);
    chk({name, "_avail"}, int'(fl.free_list_avail), av);
    chk({name, "_ovf"}, int'(fl.overflow_err), ov);
  endtask

  task automatic chk_head(input string name, input int t0, input int t1);
    chk({name, "_lane0"}, int'(fl.free_list_regs[0]), t0);
    chk({name, "_lane1"}, int'(fl.free_list_regs[1]), t1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    fl.pop_free_list = 1'b0;
    fl.push_valid    = '0;
    fl.push_reg      = '0;
    rst = 1'b1;
    cyc(0, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 0);
    rst = 1'b0;

    // 1: reset state
    chk_state("t1", 32, 1, 0);
    chk_head("t1", 32, 33);

    // 2: drain in order, then an ignored pop on the empty list
    for (int k = 0; k < 16; k++) begin
      chk_head("t2_pop", 32 + 2 * k, 33 + 2 * k);
      cyc(1, 2'b00, 0, 0);
    end
    chk_state("t2_empty", 0, 0, 0);
    cyc(1, 2'b00, 0, 0);
    chk_state("t2_extra_pop", 0, 0, 0);

    // 3: compacting push from lane 1, then lane 0
    cyc(0, 2'b10, 0, 40);
    chk_state("t3_one", 1, 0, 0);
    cyc(0, 2'b01, 41, 0);
    chk_state("t3_two", 2, 1, 0);
    chk_head("t3", 40, 41);

    // 4: pop and push together at count=2
    cyc(1, 2'b11, 50, 51);
    chk_state("t4", 2, 1, 0);
    chk_head("t4", 50, 51);

    // 5: fill, overflow, sticky flag, p0 dropped
    for (int k = 0; k < 15; k++) cyc(0, 2'b11, 2 * k + 1, 2 * k + 2);
    chk_state("t5_full", 32, 1, 0);
    cyc(0, 2'b01, 45, 0);
    chk_state("t5_ovf", 32, 1, 1);
    chk_head("t5_ovf", 50, 51);
    cyc(0, 2'b00, 0, 0);
    chk_state("t5_sticky", 32, 1, 1);
    cyc(0, 2'b01, 0, 0);
    chk_state("t5_p0_full", 32, 1, 1);
    cyc(1, 2'b11, 0, 0);
    chk_state("t5_p0_pop", 30, 1, 1);
    chk_head("t5_p0_pop", 1, 2);

    // 6: wrap of head 30 -> 0, then reset mid-operation
    rst = 1'b1;
    cyc(0, 2'b00, 0, 0);
    rst = 1'b0;
    chk_state("t6_rst", 32, 1, 0);
    for (int k = 0; k < 15; k++) cyc(1, 2'b00, 0, 0);
    chk_state("t6_low", 2, 1, 0);
    chk_head("t6_low", 62, 63);
    for (int k = 0; k < 15; k++) cyc(0, 2'b11, 2 * k + 1, 2 * k + 2);
    chk_state("t6_refill", 32, 1, 0);
    cyc(1, 2'b00, 0, 0);
    chk_head("t6_wrap", 1, 2);
    cyc(1, 2'b00, 0, 0);
    chk_head("t6_next", 3, 4);
    chk_state("t6_next", 28, 1, 0);
    rst = 1'b1;
    cyc(1, 2'b11, 7, 8);
    rst = 1'b0;
    chk_state("t6_midrst", 32, 1, 0);
    chk_head("t6_midrst", 32, 33);
    cyc(0, 2'b00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
